// File: rtl/fsm_seq_pkg.sv
// Shared types and defaults for the fsm_sequencer stimulus controller.
// Consumers: fsm_sequencer, seq_shifter.
package fsm_seq_pkg;

  localparam int unsigned DEF_SEQ_LEN    = 32;
  localparam int unsigned DEF_RST_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_shifter.sv
// Parallel-load, MSB-first shift register feeding one serial FSM input.
// The current bit is always the register MSB; each shift exposes the next one.
module seq_shifter
  import fsm_seq_pkg::*;
#(
  parameter int unsigned W = DEF_SEQ_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Load wins over shift so an accepted start always replays from the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/fsm_sequencer.sv
// Stimulus controller: holds the lab FSM in reset, then streams two latched words
// MSB-first into it while counting nonzero fsm_y samples. Y_CAPTURE_EN adds y_hist.
module fsm_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned SEQ_LEN    = DEF_SEQ_LEN,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SEQ_LEN-1:0]             seq_a,
  input  logic [SEQ_LEN-1:0]             seq_b,
  output logic                           fsm_rst,
  output logic                           fsm_a,
  output logic                           fsm_b,
  input  logic [1:0]                     fsm_y,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(SEQ_LEN+1)-1:0]   nz_cnt
`ifdef Y_CAPTURE_EN
  ,
  output logic [2*SEQ_LEN-1:0]           y_hist
`endif
);

  localparam int unsigned NZ_W   = $clog2(SEQ_LEN + 1);
  localparam int unsigned BIT_W  = cnt_width(SEQ_LEN);
  localparam int unsigned HOLD_W = cnt_width(RST_CYCLES);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SEQ_LEN - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(RST_CYCLES - 1);

  state_t              state;
  state_t              state_nx;
  logic [BIT_W-1:0]    bit_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                accept;
  logic                shift;
  logic                msb_a;
  logic                msb_b;
  logic                fsm_rst_nx;
  logic                fsm_a_nx;
  logic                fsm_b_nx;
  logic                busy_nx;
  logic                done_nx;

  assign accept = (state == IDLE) && start;
  assign shift  = (state_nx == RUN);

  seq_shifter #(.W(SEQ_LEN)) u_shift_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .din   (seq_a),
    .msb   (msb_a)
  );

  seq_shifter #(.W(SEQ_LEN)) u_shift_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .din   (seq_b),
    .msb   (msb_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, plus the output values that state_nx will present once registered.
  always_comb begin
    state_nx   = state;
    fsm_rst_nx = 1'b1;
    fsm_a_nx   = 1'b0;
    fsm_b_nx   = 1'b0;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;

    case (state)
      IDLE:    if (start) state_nx = HOLD;
      HOLD:    if (hold_cnt == LAST_HOLD) state_nx = RUN;
      RUN:     if (bit_cnt == LAST_BIT) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      HOLD: begin
        busy_nx = 1'b1;
      end
      RUN: begin
        fsm_rst_nx = 1'b0;
        busy_nx    = 1'b1;
        fsm_a_nx   = msb_a;
        fsm_b_nx   = msb_b;
      end
      DONE: begin
        fsm_rst_nx = 1'b0;
        busy_nx    = 1'b1;
        done_nx    = 1'b1;
      end
      default: ;
    endcase
  end

  // Cycle counters for HOLD and RUN; both rest at zero outside their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      bit_cnt  <= (state == RUN)  ? bit_cnt + BIT_W'(1)   : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_rst <= 1'b1;
      fsm_a   <= 1'b0;
      fsm_b   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      fsm_rst <= fsm_rst_nx;
      fsm_a   <= fsm_a_nx;
      fsm_b   <= fsm_b_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  // fsm_y is sampled at the edge closing each RUN cycle; the result holds until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_cnt <= '0;
    end else if (accept) begin
      nz_cnt <= '0;
    end else if ((state == RUN) && (fsm_y != 2'b00)) begin
      nz_cnt <= nz_cnt + NZ_W'(1);
    end
  end

`ifdef Y_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_hist <= '0;
    end else if (accept) begin
      y_hist <= '0;
    end else if (state == RUN) begin
      y_hist <= {y_hist[2*SEQ_LEN-3:0], fsm_y};
    end
  end
`endif

endmodule

// File: tb/tb_fsm_sequencer.sv
// Scoreboard bench for fsm_sequencer: each run queues one expected record per busy
// cycle; a negedge monitor pops and compares. Build with Y_CAPTURE_EN to check y_hist.
module tb_fsm_sequencer;

  localparam int unsigned SL  = 32;
  localparam int unsigned RC  = 1;
  localparam int unsigned NZW = $clog2(SL + 1);
  localparam int unsigned HW  = 2 * SL;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SL-1:0]   seq_a;
  logic [SL-1:0]   seq_b;
  logic            fsm_rst;
  logic            fsm_a;
  logic            fsm_b;
  logic [1:0]      fsm_y;
  logic            busy;
  logic            done;
  logic [NZW-1:0]  nz_cnt;
`ifdef Y_CAPTURE_EN
  logic [HW-1:0]   y_hist;
`endif

  always #5 clk = ~clk;

  fsm_sequencer #(.SEQ_LEN(SL), .RST_CYCLES(RC)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seq_a   (seq_a),
    .seq_b   (seq_b),
    .fsm_rst (fsm_rst),
    .fsm_a   (fsm_a),
    .fsm_b   (fsm_b),
    .fsm_y   (fsm_y),
    .busy    (busy),
    .done    (done),
    .nz_cnt  (nz_cnt)
`ifdef Y_CAPTURE_EN
    ,
    .y_hist  (y_hist)
`endif
  );

  typedef struct {
    logic          f_rst;
    logic          a;
    logic          b;
    logic          dn;
    int            nz;
    logic [HW-1:0] hist;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          mon_r;
  int            n_tests   = 0;
  int            n_fail    = 0;
  int            last_nz   = 0;
  logic [HW-1:0] last_hist = '0;
  bit            mon_on    = 1'b0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_fsm_rst", HW'(fsm_rst), HW'(1));
    chk("rst_fsm_a",   HW'(fsm_a),   HW'(0));
    chk("rst_fsm_b",   HW'(fsm_b),   HW'(0));
    chk("rst_busy",    HW'(busy),    HW'(0));
    chk("rst_done",    HW'(done),    HW'(0));
    chk("rst_nz_cnt",  HW'(nz_cnt),  HW'(0));
`ifdef Y_CAPTURE_EN
    chk("rst_y_hist",  y_hist,       HW'(0));
`endif
  endtask

  // Monitor: while busy, every cycle must match the next queued record; while idle, outputs rest.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("busy_unexpected", HW'(busy), HW'(0));
        end else begin
          mon_r = exp_q.pop_front();
          chk("cyc_fsm_rst", HW'(fsm_rst), HW'(mon_r.f_rst));
          chk("cyc_fsm_a",   HW'(fsm_a),   HW'(mon_r.a));
          chk("cyc_fsm_b",   HW'(fsm_b),   HW'(mon_r.b));
          chk("cyc_done",    HW'(done),    HW'(mon_r.dn));
          chk("cyc_nz_cnt",  HW'(nz_cnt),  HW'(mon_r.nz));
          if (mon_r.dn) begin
            last_nz   = mon_r.nz;
            last_hist = mon_r.hist;
`ifdef Y_CAPTURE_EN
            chk("done_y_hist", y_hist, mon_r.hist);
`endif
          end
        end
      end else begin
        chk("idle_fsm_rst", HW'(fsm_rst), HW'(1));
        chk("idle_fsm_a",   HW'(fsm_a),   HW'(0));
        chk("idle_fsm_b",   HW'(fsm_b),   HW'(0));
        chk("idle_done",    HW'(done),    HW'(0));
        chk("idle_nz_hold", HW'(nz_cnt),  HW'(last_nz));
`ifdef Y_CAPTURE_EN
        chk("idle_y_hist_hold", y_hist, last_hist);
`endif
      end
    end
  end

  // Change the (ignored) request and data inputs after acceptance.
  task automatic poke(input bit ign);
    start = ign;
    seq_a = $urandom;
    seq_b = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_vals();
    last_nz   = 0;
    last_hist = '0;
    start     = 1'b0;
    fsm_y     = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One run, entered and left one step after a rising edge with the DUT idle.
  // ymode: 0 tied 01, 1 tied 00, 2 alternating 00/10, 3 first 11 then 00, else random.
  task automatic run_seq(input logic [SL-1:0] wa, input logic [SL-1:0] wb,
                         input int ymode, input bit ign, input int abort_at);
    logic [1:0]    ys[SL];
    int            cnt;
    logic [HW-1:0] h;
    rec_t          r;

    for (int k = 0; k < SL; k++) begin
      case (ymode)
        0:       ys[k] = 2'b01;
        1:       ys[k] = 2'b00;
        2:       ys[k] = (k % 2 == 0) ? 2'b00 : 2'b10;
        3:       ys[k] = (k == 0) ? 2'b11 : 2'b00;
        default: ys[k] = 2'($urandom_range(0, 3));
      endcase
    end

    for (int i = 0; i < int'(RC); i++) begin
      r.f_rst = 1'b1; r.a = 1'b0; r.b = 1'b0; r.dn = 1'b0; r.nz = 0; r.hist = '0;
      exp_q.push_back(r);
    end
    cnt = 0;
    h   = '0;
    for (int k = 0; k < SL; k++) begin
      r.f_rst = 1'b0; r.a = wa[SL-1-k]; r.b = wb[SL-1-k]; r.dn = 1'b0; r.nz = cnt; r.hist = '0;
      exp_q.push_back(r);
      if (ys[k] != 2'b00) cnt++;
      h[HW-1-2*k -: 2] = ys[k];
    end
    r.f_rst = 1'b0; r.a = 1'b0; r.b = 1'b0; r.dn = 1'b1; r.nz = cnt; r.hist = h;
    exp_q.push_back(r);

    start = 1'b1;
    seq_a = wa;
    seq_b = wb;
    @(posedge clk); #1;
    for (int i = 0; i < int'(RC); i++) begin
      poke(ign);
      @(posedge clk); #1;
    end
    for (int k = 0; k < SL; k++) begin
      fsm_y = ys[k];
      poke(ign);
      if (k == abort_at) begin
        do_reset();
        return;
      end
      @(posedge clk); #1;
    end
    fsm_y = 2'b00;
    poke(ign);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  localparam logic [SL-1:0] NOM_A = 32'hD4B35ADD;
  localparam logic [SL-1:0] NOM_B = 32'h586A94B9;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    seq_a = '0;
    seq_b = '0;
    fsm_y = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst    = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    run_seq(NOM_A, NOM_B, 0, 1'b0, -1);
    run_seq(NOM_A, NOM_B, 1, 1'b0, -1);
    run_seq(NOM_A, NOM_B, 2, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    run_seq(NOM_A, NOM_B, 3, 1'b0, -1);
    run_seq(NOM_A, NOM_B, 4, 1'b1, -1);
    run_seq(NOM_A, NOM_B, 0, 1'b0, -1);
    run_seq(NOM_A, NOM_B, 0, 1'b0, 10);
    run_seq(NOM_A, NOM_B, 0, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_seq($urandom, $urandom, 4, 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", HW'(exp_q.size()), HW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
